// File: rtl/fdst7_pkg.sv
// Shared constants and arithmetic helpers for the 4-point forward DST-VII core.
package fdst7_pkg;

   localparam int COEF_W   = 7;
   localparam int REF_IN_W = 16;
   // Widths at the reference 16-bit input; the datapath scales them with IN_W
   localparam int PROD_W   = 23;
   localparam int SUM_W    = 25;
   localparam int RND_W    = 26;

   localparam logic [COEF_W-1:0] MAG_29 = 7'd29;
   localparam logic [COEF_W-1:0] MAG_55 = 7'd55;
   localparam logic [COEF_W-1:0] MAG_74 = 7'd74;
   localparam logic [COEF_W-1:0] MAG_84 = 7'd84;

   // Bit (4*k+n) is set where C[k][n] is negative
   localparam logic [15:0] COEF_NEG = 16'b1010_0110_1000_0000;

   function automatic logic [COEF_W-1:0] coef_mag(input int k, input int n);
      logic [COEF_W-1:0] m;
      case (4*k + n)
         0, 9, 15:             m = MAG_29;
         1, 11, 12:            m = MAG_55;
         2, 4, 5, 7, 10, 14:   m = MAG_74;
         3, 8, 13:             m = MAG_84;
         default:              m = '0;
      endcase
      return m;
   endfunction

   // Add half an LSB of the result, then arithmetic shift (floors toward -inf)
   function automatic logic signed [63:0] round_shift(input logic signed [63:0] v, input int sh);
      logic signed [63:0] off;
      off = (sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0;
      return (v + off) >>> sh;
   endfunction

endpackage

// File: rtl/fdst7_cmul.sv
// Registered constant multiplier: unsigned 7-bit magnitude times a signed sample.
module fdst7_cmul
   import fdst7_pkg::*;
#(
   parameter int                IN_W = 16,
   parameter logic [COEF_W-1:0] MAG  = MAG_29
) (
   input  logic                          i_clk,
   input  logic                          i_en,
   input  logic signed [IN_W-1:0]        i_x,
   output logic signed [IN_W+COEF_W-1:0] o_p
);

   localparam int PW = IN_W + COEF_W;

   logic signed [PW-1:0] w_m;
   logic signed [PW-1:0] w_xe;
   logic signed [PW-1:0] r_p;

   assign w_m  = $signed(PW'(MAG));
   assign w_xe = PW'(i_x);

   always_ff @(posedge i_clk)
      if (i_en) r_p <= w_m * w_xe;

   assign o_p = r_p;

endmodule

// File: rtl/fdst7_4pt_pipe.sv
// 4-point forward DST-VII, 4-stage pipeline with a single global stall enable.
// Define FDST7_SAT_EN for saturating output plus sticky sat_flag; otherwise results wrap.
module fdst7_4pt_pipe
   import fdst7_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 16,
   parameter int SHIFT = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*IN_W-1:0]    in_x,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*OUT_W-1:0]   out_y
`ifdef FDST7_SAT_EN
   ,
   output logic                 sat_flag
`endif
);

   localparam int PW = IN_W + (PROD_W - REF_IN_W);
   localparam int SW = IN_W + (SUM_W - REF_IN_W);
   localparam int RW = IN_W + (RND_W - REF_IN_W);

   logic                   w_en;
   logic [3:0]             r_vld;
   logic signed [IN_W-1:0] r_x   [4];
   logic signed [PW-1:0]   w_p   [4][4];
   logic signed [SW-1:0]   w_t   [4][4];
   logic signed [SW-1:0]   w_sum [4];
   logic signed [SW-1:0]   r_sum [4];
   logic [3:0][OUT_W-1:0]  w_y;
   logic [3:0][OUT_W-1:0]  r_y;

   assign w_en      = !r_vld[3] || out_ready;
   assign in_ready  = w_en;
   assign out_valid = r_vld[3];
   assign out_y     = r_y;

   always_ff @(posedge clk or posedge reset)
      if (reset)     r_vld <= '0;
      else if (w_en) r_vld <= {r_vld[2:0], in_valid};

   // S0
   always_ff @(posedge clk)
      if (w_en)
         for (int n = 0; n < 4; n++) r_x[n] <= in_x[n*IN_W +: IN_W];

   // S1: one multiplier per nonzero matrix entry; sign is folded in before the adders
   for (genvar k = 0; k < 4; k++) begin : g_row
      for (genvar n = 0; n < 4; n++) begin : g_col
         localparam logic [COEF_W-1:0] MAG = coef_mag(k, n);
         localparam logic              NEG = COEF_NEG[4*k + n];
         if (MAG != '0) begin : g_mul
            fdst7_cmul #(.IN_W(IN_W), .MAG(MAG)) u_mul (
               .i_clk (clk),
               .i_en  (w_en),
               .i_x   (r_x[n]),
               .o_p   (w_p[k][n])
            );
         end else begin : g_zero
            assign w_p[k][n] = '0;
         end
         assign w_t[k][n] = NEG ? -SW'(w_p[k][n]) : SW'(w_p[k][n]);
      end
   end

   // S2
   always_comb
      for (int k = 0; k < 4; k++)
         w_sum[k] = w_t[k][0] + w_t[k][1] + w_t[k][2] + w_t[k][3];

   always_ff @(posedge clk)
      if (w_en) r_sum <= w_sum;

   // S3: round, shift, then clip or wrap
`ifdef FDST7_SAT_EN
   localparam logic signed [RW-1:0] YMAX = RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [RW-1:0] YMIN = ~YMAX;

   logic signed [RW-1:0] w_rs [4];
   logic [3:0]           w_clip;
   logic                 r_sat;

   always_comb begin
      w_clip = '0;
      for (int k = 0; k < 4; k++) begin
         w_rs[k] = RW'(round_shift(64'(r_sum[k]), SHIFT));
         if (w_rs[k] > YMAX) begin
            w_y[k]    = YMAX[OUT_W-1:0];
            w_clip[k] = 1'b1;
         end else if (w_rs[k] < YMIN) begin
            w_y[k]    = YMIN[OUT_W-1:0];
            w_clip[k] = 1'b1;
         end else begin
            w_y[k]    = w_rs[k][OUT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset)
      if (reset)                             r_sat <= 1'b0;
      else if (w_en && r_vld[2] && |w_clip)  r_sat <= 1'b1;

   assign sat_flag = r_sat;
`else
   always_comb
      for (int k = 0; k < 4; k++)
         w_y[k] = OUT_W'(RW'(round_shift(64'(r_sum[k]), SHIFT)));
`endif

   // Only real beats load the output, so out_y stays 0 from reset until the first result
   always_ff @(posedge clk or posedge reset)
      if (reset)                  r_y <= '0;
      else if (w_en && r_vld[2])  r_y <= w_y;

endmodule

// File: tb/tb_fdst7_4pt_pipe.sv
// Self-checking bench for fdst7_4pt_pipe: directed vectors, stall/reset sequences,
// and random traffic scored against a plain matrix-multiply model.
module tb_fdst7_4pt_pipe;

   localparam int IN_W  = 16;
   localparam int OUT_W = 16;
   localparam int SHIFT = 3;
   localparam int CM [4][4] = '{'{29, 55, 74, 84}, '{74, 74, 0, -74},
                                '{84, -29, -74, 55}, '{55, -84, 74, -29}};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_x = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_y;
`ifdef FDST7_SAT_EN
   logic        sat_flag;
`endif

   int          checks = 0;
   int          errors = 0;
   int          n_out  = 0;
   logic [63:0] q[$];

   always #5 clk = ~clk;

   fdst7_4pt_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y)
`ifdef FDST7_SAT_EN
      ,
      .sat_flag  (sat_flag)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
      logic [63:0] r;
      r[15:0]  = a[15:0];
      r[31:16] = b[15:0];
      r[47:32] = c[15:0];
      r[63:48] = d[15:0];
      return r;
   endfunction

   function automatic logic [63:0] model(input logic [63:0] x);
      logic [63:0] y;
      longint      s, r;
      for (int k = 0; k < 4; k++) begin
         s = 0;
         for (int n = 0; n < 4; n++)
            s += longint'(CM[k][n]) * longint'($signed(x[n*16 +: 16]));
         r = s + ((SHIFT > 0) ? (longint'(1) <<< (SHIFT - 1)) : longint'(0));
         r = r >>> SHIFT;
`ifdef FDST7_SAT_EN
         if (r > 32767)  r = 32767;
         if (r < -32768) r = -32768;
`endif
         y[k*16 +: 16] = r[15:0];
      end
      return y;
   endfunction

   function automatic logic [63:0] rand_x();
      if ($urandom_range(0, 1) == 0)
         return {$urandom, $urandom};
      return pack4(int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200,
                   int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: inputs are stable from posedge+1, so the negedge view matches the next edge
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: out_y=%h with nothing pending", out_y);
         end else begin
            chk("scoreboard", out_y, q[0]);
            if (out_ready) begin
               void'(q.pop_front());
               n_out++;
            end
         end
      end
      if (!reset && in_valid && in_ready) q.push_back(model(in_x));
   end

   typedef struct {
      logic [63:0] x;
      logic [63:0] y;
      logic        all;
      string       nm;
   } vec_t;

   vec_t tbl [5];

   task automatic apply_vec(input vec_t v);
      int lat;
      in_valid = 1'b1;
      in_x     = v.x;
      @(negedge clk);
      chk({v.nm, "_in_ready"}, 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
      chk({v.nm, "_latency"}, 64'(lat), 64'd3);
      if (v.all) chk({v.nm, "_y"}, out_y, v.y);
      else       chk({v.nm, "_y0"}, 64'(out_y[15:0]), 64'(v.y[15:0]));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int nb;
      int t;

      tbl[0] = '{pack4(64, 0, 0, 0),        pack4(232, 592, 672, 440), 1'b1, "impulse"};
      tbl[1] = '{pack4(100, 100, 100, 100), pack4(3025, 925, 450, 200), 1'b1, "dc"};
      tbl[2] = '{pack4(-1, 0, 0, 0),        pack4(-4, -9, -10, -7),     1'b1, "neg_round"};
`ifdef FDST7_SAT_EN
      tbl[3] = '{pack4(32767, 32767, 32767, 32767),     pack4(32767, 0, 0, 0),  1'b0, "max_in"};
      tbl[4] = '{pack4(-32768, -32768, -32768, -32768), pack4(-32768, 0, 0, 0), 1'b0, "min_in"};
`else
      tbl[3] = '{pack4(32767, 32767, 32767, 32767),     pack4(8162, 0, 0, 0),   1'b0, "max_in"};
      tbl[4] = '{pack4(-32768, -32768, -32768, -32768), pack4(-8192, 0, 0, 0),  1'b0, "min_in"};
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_y", out_y, 64'd0);
      reset = 1'b0;
      #1;
      chk("reset_in_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < 5; i++) begin
`ifdef FDST7_SAT_EN
         if (i == 3) chk("sat_flag_clear", 64'(sat_flag), 64'd0);
`endif
         apply_vec(tbl[i]);
      end
`ifdef FDST7_SAT_EN
      chk("sat_flag_set", 64'(sat_flag), 64'd1);
`endif

      // Backpressure: 6 beats, downstream stalls 5 cycles once the first result shows
      nb = n_out;
      fork
         begin : drv
            int  tw;
            logic ok;
            for (int b = 0; b < 6; b++) begin
               in_valid = 1'b1;
               in_x     = rand_x();
               tw = 0;
               do begin
                  @(negedge clk);
                  ok = in_ready;
                  tick();
                  tw++;
               end while (!ok && tw < 50);
               if (!ok) chk("bp_accept_timeout", 64'd0, 64'd1);
            end
            in_valid = 1'b0;
         end
         begin : stl
            int ts;
            ts = 0;
            while (!out_valid && ts < 50) begin
               tick();
               ts++;
            end
            out_ready = 1'b0;
            #1;
            chk("bp_in_ready_drop", 64'(in_ready), 64'd0);
            repeat (5) begin
               @(negedge clk);
               chk("bp_in_ready_low", 64'(in_ready), 64'd0);
               chk("bp_out_valid_held", 64'(out_valid), 64'd1);
               tick();
            end
            out_ready = 1'b1;
         end
      join
      t = 0;
      while (q.size() != 0 && t < 50) begin
         tick();
         t++;
      end
      chk("bp_beat_count", 64'(n_out - nb), 64'd6);

      // Random traffic on both sides
      for (int c = 0; c < 300; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_x      = rand_x();
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      t = 0;
      while (q.size() != 0 && t < 50) begin
         tick();
         t++;
      end
      chk("rand_drain", 64'(q.size()), 64'd0);

      // Reset with a result on the output and three more beats behind it
      for (int b = 0; b < 4; b++) begin
         in_valid = 1'b1;
         in_x     = pack4(100 + 7*b, -50, 30, 9);
         tick();
      end
      in_valid = 1'b0;
      chk("rst_pre_out_valid", 64'(out_valid), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst_async_out_valid", 64'(out_valid), 64'd0);
      chk("rst_async_out_y", out_y, 64'd0);
      q.delete();
      repeat (2) @(posedge clk);
      #1;
`ifdef FDST7_SAT_EN
      chk("rst_sat_flag", 64'(sat_flag), 64'd0);
`endif
      reset = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      nb = n_out;
      repeat (10) tick();
      chk("rst_no_stale_beats", 64'(n_out - nb), 64'd0);
      chk("rst_out_valid_idle", 64'(out_valid), 64'd0);
      chk("rst_out_y_idle", out_y, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
